// File: rtl/dmem_access_ctrl_pkg.sv
// Shared pipeline definitions for the MEM-stage data-memory access controller.
// Holds the controller FSM encoding, EX/MEM m-field bit positions and counter width.
// No logic; imported by dmem_access_ctrl.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    // Bit positions inside the EX/MEM m field
    localparam int M_READ_BIT  = 1;
    localparam int M_WRITE_BIT = 0;

    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: req/ack handshake with variable-latency memory, global pipeline stall.
// Latency: request one cycle after the access is seen, DONE one cycle after ack; stall = 2+L cycles.
// Backpressure: stall_o freezes all pipeline registers until ack; optional DMEM_TIMEOUT_EN aborts long waits.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DW-1:0]          wdata_i,
    output logic                   stall_o,
    output logic [DW-1:0]          rdata_o,
    output logic                   rdata_valid_o,
    output logic                   mreq_o,
    output logic                   mwe_o,
    output logic [AW-1:0]          maddr_o,
    output logic [DW-1:0]          mwdata_o,
    input  logic                   mack_i,
    input  logic [DW-1:0]          mrdata_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`ifdef DMEM_TIMEOUT_EN
    ,
    output logic                   err_o
`endif
);

    dmem_state_t state;
    logic [1:0]  m_field;
    logic        access;

`ifdef DMEM_TIMEOUT_EN
    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [WCW-1:0] wait_cnt;
`endif

    // Reassemble the EX/MEM m field; a store wins when both bits are set
    always_comb begin
        m_field              = '0;
        m_field[M_READ_BIT]  = mem_read_i;
        m_field[M_WRITE_BIT] = mem_write_i;
        access               = |m_field;
    end

    // Stall only from state and EX/MEM bits, never from mack_i
    assign stall_o = ((state == ST_IDLE) && access) || (state == ST_BUSY);

    // Access FSM with registered memory-side and load-return outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            mreq_o        <= 1'b0;
            mwe_o         <= 1'b0;
            maddr_o       <= '0;
            mwdata_o      <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt      <= '0;
            err_o         <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        maddr_o  <= addr_i;
                        mwdata_o <= wdata_i;
                        mwe_o    <= m_field[M_WRITE_BIT];
                        mreq_o   <= 1'b1;
                        state    <= ST_BUSY;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (mack_i) begin
                        if (!mwe_o) begin
                            rdata_o <= mrdata_i;
                        end
                        rdata_valid_o <= !mwe_o;
                        mreq_o        <= 1'b0;
                        state         <= ST_DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    // Last permitted wait cycle without ack: abort with zero data
                    else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        rdata_o       <= '0;
                        rdata_valid_o <= !mwe_o;
                        err_o         <= 1'b1;
                        mreq_o        <= 1'b0;
                        state         <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
`endif
                end
                ST_DONE: begin
                    // EX/MEM still holds the finished instruction; ignore access here
                    rdata_valid_o <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller for the MEM stage of the 5-stage pipeline. It takes the memory control bits and operands held in the EX/MEM pipeline register, runs a request/acknowledge transaction with a variable-latency data memory, and drives the global `stall_o` that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB until the access completes. It also returns load data to MEM/WB and counts stall cycles for performance monitoring.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, maximum number of cycles in BUSY before abort; used only with `DMEM_TIMEOUT_EN`

Ports:
- `clk_i`  in  1  clock, all state updates on its rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `mem_read_i`  in  1  load in EX/MEM (`m_o[1]`)
- `mem_write_i`  in  1  store in EX/MEM (`m_o[0]`)
- `addr_i`  in  AW  ALU result from EX/MEM
- `wdata_i`  in  DW  store data from EX/MEM
- `stall_o`  out  1  pipeline freeze, to every pipeline register `stall_i`
- `rdata_o`  out  DW  load data to MEM/WB
- `rdata_valid_o`  out  1  `rdata_o` is valid in this cycle
- `mreq_o`  out  1  memory request
- `mwe_o`  out  1  write enable, qualified by `mreq_o`
- `maddr_o`  out  AW  memory address
- `mwdata_o`  out  DW  memory write data
- `mack_i`  in  1  memory acknowledge; one-cycle pulse
- `mrdata_i`  in  DW  read data, valid when `mack_i`=1
- `stall_cnt_o`  out  32  saturating count of cycles with `stall_o`=1
- `err_o`  out  1  sticky timeout flag; present only with `DMEM_TIMEOUT_EN`

## Operation
- `access` = `mem_read_i | mem_write_i`. If both are 1, the access is treated as a write.
- FSM states:
  - IDLE
    - `access`=1: latch `addr_i`, `wdata_i` and write flag into `maddr_o`/`mwdata_o`/`mwe_o`, then go to BUSY.
    - `access`=0: stay in IDLE.
  - BUSY
    - `mreq_o`=1 and the latched request is held stable.
    - On `mack_i`=1: `rdata_o` <= `mrdata_i` for a read, otherwise `rdata_o` is unchanged; go to DONE.
  - DONE
    - `rdata_valid_o`=1 for a read.
    - `access` is ignored here, because EX/MEM still holds the completed instruction.
    - Always go to IDLE next.
- `stall_o` = (IDLE & `access`) | BUSY. It is combinational from state and inputs; there is no combinational path from `mack_i`.
- `mack_i` outside BUSY is ignored.
- `stall_cnt_o` increments every cycle `stall_o`=1 and saturates at 0xFFFFFFFF.

## Timing
- Reset values: state IDLE, `mreq_o`=0, `mwe_o`=0, `maddr_o`=0, `mwdata_o`=0, `rdata_o`=0, `rdata_valid_o`=0, `stall_cnt_o`=0, `err_o`=0.
- Sequence for an access first visible in cycle t (IDLE) with the ack L cycles after `mreq_o` rises (L≥0):
  - `mreq_o` rises at t+1.
  - `mack_i` arrives at t+1+L.
  - DONE is at t+2+L.
  - `stall_o`=1 for cycles t..t+1+L, i.e. 2+L stall cycles.
- In DONE, `stall_o`=0, so the pipeline advances at the end of DONE. A memory op arriving in the following cycle is accepted from IDLE.
- `mreq_o` deasserts in the cycle after `mack_i`.
- `rst_i` in BUSY or DONE: the next cycle is IDLE with all outputs at reset values, and any outstanding transaction is abandoned. Memory-side cleanup is the memory's responsibility.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT`, the FSM goes to DONE, `rdata_o` <= 0, and `err_o` is set; `err_o` stays set until `rst_i`.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- `DMEM_TIMEOUT_EN` undefined: no counter, no `err_o` port, and BUSY waits indefinitely.

## Structure
- Shared pipeline package holds:
  - FSM state encoding `dmem_state_t` (IDLE, BUSY, DONE)
  - `M_READ_BIT`=1 and `M_WRITE_BIT`=0 indices into the EX/MEM `m` field
  - `STALL_CNT_W`=32
- Single module with no sub-modules. The saturating counter is small enough to stay inline.

## Test plan
- Load at addr 0x10, `mack_i` on the first BUSY cycle with `mrdata_i`=0xCAFEF00D -> `stall_o` high exactly 2 cycles, `rdata_o`=0xCAFEF00D with `rdata_valid_o` in DONE, `stall_cnt_o`=2.
- Store at addr 0x20 with data 0x12345678, ack after 5 cycles -> `mwe_o`=1, `maddr_o`/`mwdata_o` stable for all 6 request cycles, 7 stall cycles, `rdata_valid_o` never asserted.
- Back-to-back load then store, ack L=0 each -> second access leaves IDLE in the cycle after DONE, no duplicate request for the first instruction, `stall_cnt_o`=4.
- `rst_i` pulsed in the third BUSY cycle -> next cycle `mreq_o`=0, `stall_o`=0, `stall_cnt_o`=0; a late `mack_i` is ignored.
- `DMEM_TIMEOUT_EN`, `TIMEOUT`=4, no ack -> DONE after 4 BUSY cycles, `err_o`=1 sticky, `rdata_o`=0. Repeat with the ack in the 4th cycle -> `err_o`=0.
